inv_key_sched: RTL

- Iterative AES-128 key schedule that sits directly upstream of the inverse round datapath.
- Accepts a 128-bit cipher key and expands it sequentially, one round key per clock, into an internal 11-entry round-key store.
- Then serves round keys by index to the inverse-round stage. The decryption controller reads indices 10 down to 0, matching the round's 4-bit rc index.

---
 rtl/inv_key_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/inv_key_sched.sv
// Iterative AES-128 key schedule feeding the inverse round datapath.
// A cipher key is expanded one round key per clock into an 11-entry
// store, then round keys are served by index with one cycle of latency.

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the inverse of x (and maps 0 to 0); built from x^2, x^4 ... x^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform with constant 0x63.
  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state, state_next;
  logic [3:0]   cnt, cnt_next;
  logic         load_en, step_en;
  logic [127:0] rk [0:NR];
  // Copy of the most recently written round key, so the expansion step
  // never competes with the read port for the store.
  logic [127:0] last_key;

  logic [31:0]  w0, w1, w2, w3, rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [127:0] new_key;

  assign {w0, w1, w2, w3} = last_key;
  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sb0 (.in_byte(rot[31:24]), .out_byte(sub[31:24]));
  aes_sbox u_sb1 (.in_byte(rot[23:16]), .out_byte(sub[23:16]));
  aes_sbox u_sb2 (.in_byte(rot[15:8]),  .out_byte(sub[15:8]));
  aes_sbox u_sb3 (.in_byte(rot[7:0]),   .out_byte(sub[7:0]));

  // Round constant for the key currently being produced (index = cnt).
  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t       = sub ^ {rcon, 24'h000000};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign new_key = {n0, n1, n2, n3};

  // State and round counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: accept a key in IDLE/READY, step once per cycle in EXPAND.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_en    = 1'b0;
    step_en    = 1'b0;
    case (state)
      IDLE, READY: begin
        if (load_valid) begin
          load_en    = 1'b1;
          state_next = EXPAND;
          cnt_next   = 4'd1;
        end
      end
      EXPAND: begin
        step_en = 1'b1;
        if (cnt == LAST) begin
          state_next = READY;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Round-key store writes; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && load_en) begin
      rk[0]    <= key_in;
      last_key <= key_in;
    end else if (!rst && step_en) begin
      rk[cnt]  <= new_key;
      last_key <= new_key;
    end
  end

  // Registered read port; zero whenever keys are not valid or index is out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
    end else if (keys_ready && rd_idx <= LAST) begin
      rd_key <= rk[rd_idx];
    end else begin
      rd_key <= '0;
    end
  end

  assign load_ready = (state != EXPAND);
  assign keys_ready = (state == READY);
  assign busy       = (state == EXPAND);

endmodule
